clock_set_ctrl: RTL

Mode/sequencing controller for the seconds/minutes timekeeping counter. Generates the 1 Hz count-enable tick from the system clock and runs a RUN/SET FSM. The FSM lets a user edit minutes and seconds with two buttons, then loads the edited time into the counter datapath. It sits between the button front-end and the counter, which has count-enable and synchronous-load inputs.

---
 rtl/clock_set_ctrl_pkg.sv | 38 +++
 rtl/clock_set_ctrl_if.sv | 35 +++
 rtl/clock_set_ctrl_btn_sync_edge.sv | 39 +++
 rtl/clock_set_ctrl.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/clock_set_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// clock_ctrl_pkg
// Shared types, limits and helpers for the clock set controller.
//   ctrl_state_t : RUN / SET_MIN / SET_SEC / COMMIT encoding (also the mode
//                  output value seen by the display).
//   MAX_SEC/MAX_MIN : largest legal value of a seconds/minutes field.
//   inc_wrap59   : +1 with wrap from 59 back to 0.
//   clamp59      : forces an out-of-range captured value to 0.
// -----------------------------------------------------------------------------
package clock_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_MIN = 2'd1,
    SET_SEC = 2'd2,
    COMMIT  = 2'd3
  } ctrl_state_t;

  localparam logic [5:0] MAX_SEC = 6'd59;
  localparam logic [5:0] MAX_MIN = 6'd59;

  // Anything at or above 59 wraps to 0 so a corrupted field can never
  // walk past the legal range.
  function automatic logic [5:0] inc_wrap59(input logic [5:0] val);
    logic [5:0] res;
    if (val >= MAX_MIN) res = 6'd0;
    else                res = val + 6'd1;
    return res;
  endfunction

  function automatic logic [5:0] clamp59(input logic [5:0] val);
    logic [5:0] res;
    if (val > MAX_SEC) res = 6'd0;
    else               res = val;
    return res;
  endfunction

endpackage

// File: rtl/clock_set_ctrl_if.sv
// -----------------------------------------------------------------------------
// clock_set_ctrl_if
// Bundle between the set controller and the timekeeping counter / display.
//   cur_sec, cur_min : current time from the counter (counter -> controller)
//   tick             : 1 Hz count enable (controller -> counter)
//   load             : one-cycle synchronous load strobe
//   load_sec/min     : value to load, valid while load=1
//   edit_val         : field being edited, for the display
//   mode             : controller state encoding
//   blink            : display blink enable
// master = controller side, slave = counter/display side.
// -----------------------------------------------------------------------------
interface clock_set_ctrl_if;

  logic [5:0] cur_sec;
  logic [5:0] cur_min;
  logic       tick;
  logic       load;
  logic [5:0] load_sec;
  logic [5:0] load_min;
  logic [5:0] edit_val;
  logic [1:0] mode;
  logic       blink;

  modport master (
    input  cur_sec, cur_min,
    output tick, load, load_sec, load_min, edit_val, mode, blink
  );

  modport slave (
    output cur_sec, cur_min,
    input  tick, load, load_sec, load_min, edit_val, mode, blink
  );

endinterface

// File: rtl/clock_set_ctrl_btn_sync_edge.sv
// -----------------------------------------------------------------------------
// btn_sync_edge
// Synchronises an asynchronous active-high button level and emits a single
// one-cycle pulse on each rising edge of the synchronised level.
// Press-to-pulse latency is SYNC_STAGES+1 clocks (pulse is registered).
//   clk   : system clock
//   rst   : asynchronous active-low reset
//   btn   : raw button level
//   pulse : one-cycle pulse per press
// -----------------------------------------------------------------------------
module btn_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   level;

  assign level = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      pulse  <= 1'b0;
    end else begin
      // shift form keeps SYNC_STAGES=1 legal
      sync_q <= (sync_q << 1) | SYNC_STAGES'(btn);
      prev_q <= level;
      pulse  <= level & ~prev_q;
    end
  end

endmodule

// File: rtl/clock_set_ctrl.sv
// -----------------------------------------------------------------------------
// clock_set_ctrl
// RUN/SET sequencer for the seconds/minutes timekeeping counter. Generates the
// 1 Hz count enable from clk, lets the user edit minutes then seconds with the
// mode/inc buttons, and loads the edited time into the counter on commit.
// Unattended edits are abandoned after TIMEOUT_TICKS ticks.
//   clk      : system clock, rising edge
//   rst      : asynchronous active-low reset
//   btn_mode : raw mode button (async, active-high)
//   btn_inc  : raw increment button (async, active-high)
//   bus      : counter/display bundle (see clock_set_ctrl_if)
//
// state   | meaning
// --------+-----------------------------------------------------------
// RUN     | normal timekeeping, tick passed to counter, inc ignored
// SET_MIN | editing minutes, counter frozen, blink toggles per tick
// SET_SEC | editing seconds, counter frozen, blink toggles per tick
// COMMIT  | single cycle: load strobe, prescaler restarted, back to RUN
// -----------------------------------------------------------------------------
module clock_set_ctrl
  import clock_ctrl_pkg::*;
#(
  parameter int TICK_DIV      = 50_000_000,
  parameter int TIMEOUT_TICKS = 10,
  parameter int SYNC_STAGES   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_mode,
  input  logic             btn_inc,
  clock_set_ctrl_if.master bus
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int TW = (TIMEOUT_TICKS > 1) ? $clog2(TIMEOUT_TICKS + 1) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_TICKS - 1);

  localparam logic [1:0] ST_RUN     = RUN;
  localparam logic [1:0] ST_SET_MIN = SET_MIN;
  localparam logic [1:0] ST_SET_SEC = SET_SEC;
  localparam logic [1:0] ST_COMMIT  = COMMIT;

  logic          mode_p;
  logic          inc_p;

  logic [PW-1:0] presc_q;
  logic          tick_int;

  logic [1:0]    state_q,    state_d;
  logic [5:0]    edit_min_q, edit_min_d;
  logic [5:0]    edit_sec_q, edit_sec_d;
  logic [TW-1:0] tmo_q,      tmo_d;
  logic          blink_q,    blink_d;
  logic          load_upd;
  logic [5:0]    load_min_q;
  logic [5:0]    load_sec_q;
  logic          in_set;

  btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mode (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_mode),
    .pulse (mode_p)
  );

  btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_inc (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_inc),
    .pulse (inc_p)
  );

  // Prescaler. Restarting it in COMMIT makes the first second after a load
  // a full TICK_DIV cycles long.
  assign tick_int = (presc_q == PRESC_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q <= '0;
    end else if (state_q == ST_COMMIT || tick_int) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + 1'b1;
    end
  end

  assign in_set = (state_q == ST_SET_MIN) || (state_q == ST_SET_SEC);

  always_comb begin
    state_d    = state_q;
    edit_min_d = edit_min_q;
    edit_sec_d = edit_sec_q;
    tmo_d      = tmo_q;
    load_upd   = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (mode_p) begin
          state_d    = ST_SET_MIN;
          edit_min_d = clamp59(bus.cur_min);
          edit_sec_d = clamp59(bus.cur_sec);
          tmo_d      = '0;
        end
      end

      ST_SET_MIN, ST_SET_SEC: begin
        // mode has priority over inc when both land in the same cycle
        if (mode_p) begin
          tmo_d = '0;
          if (state_q == ST_SET_MIN) begin
            state_d = ST_SET_SEC;
          end else begin
            state_d  = ST_COMMIT;
            load_upd = 1'b1;
          end
        end else if (inc_p) begin
          tmo_d = '0;
          if (state_q == ST_SET_MIN) edit_min_d = inc_wrap59(edit_min_q);
          else                       edit_sec_d = inc_wrap59(edit_sec_q);
        end else if (tick_int) begin
          if (tmo_q >= TMO_LAST) begin
            state_d = ST_RUN;
            tmo_d   = '0;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end
      end

      ST_COMMIT: begin
        state_d = ST_RUN;
      end

      default: begin
        state_d = ST_RUN;
      end
    endcase

    if (state_d == ST_RUN)      blink_d = 1'b0;
    else if (in_set && tick_int) blink_d = ~blink_q;
    else                         blink_d = blink_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_RUN;
      edit_min_q <= 6'd0;
      edit_sec_q <= 6'd0;
      tmo_q      <= '0;
      blink_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      edit_min_q <= edit_min_d;
      edit_sec_q <= edit_sec_d;
      tmo_q      <= tmo_d;
      blink_q    <= blink_d;
    end
  end

  // Load value is captured on the edge into COMMIT so it is already stable
  // while the load strobe is high, and held afterwards.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      load_min_q <= 6'd0;
      load_sec_q <= 6'd0;
    end else if (load_upd) begin
      load_min_q <= edit_min_q;
      load_sec_q <= edit_sec_q;
    end
  end

  always_comb begin
    case (state_q)
      ST_SET_MIN: bus.edit_val = edit_min_q;
      ST_SET_SEC: bus.edit_val = edit_sec_q;
      default:    bus.edit_val = 6'd0;
    endcase
  end

  assign bus.tick     = tick_int && (state_q == ST_RUN);
  assign bus.load     = (state_q == ST_COMMIT);
  assign bus.load_min = load_min_q;
  assign bus.load_sec = load_sec_q;
  assign bus.mode     = state_q;
  assign bus.blink    = blink_q;

endmodule
